// File: rtl/stream_packer_pkg.sv
// Shared constants and the flush-padding helper for the 8-to-32 stream packer.
package stream_packer_pkg;

  localparam int LANES        = 4;
  localparam int LANE_W       = 2;
  localparam logic [7:0] PAD_DEFAULT = 8'h00;
  localparam int STAT_WORDS_W = 32;
  localparam int STAT_PADS_W  = 16;

  // Lanes below `lane` carry assembled bytes; lane `lane` and above get the pad value.
  function automatic logic [31:0] pad_word(input logic [23:0]       asm,
                                           input logic [LANE_W-1:0] lane,
                                           input logic [7:0]        pad);
    logic [31:0] w;
    w = {pad, asm};
    for (int i = 0; i < LANES; i++) begin
      if (i >= int'(lane)) w[i*8 +: 8] = pad;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_packer_stats.sv
// Word/pad event counters for the stream packer; built only when STREAM_PACKER_STATS_EN is defined.
module stream_packer_stats
  import stream_packer_pkg::*;
(
  input  logic                    bus_clk,
  input  logic                    bus_rst_n,
  input  logic                    clr,
  input  logic                    inc_word,
  input  logic                    inc_pad,
  output logic [STAT_WORDS_W-1:0] stat_words,
  output logic [STAT_PADS_W-1:0]  stat_pads
);

  logic [STAT_WORDS_W-1:0] words_q, words_d;
  logic [STAT_PADS_W-1:0]  pads_q, pads_d;

  // A clear on the open edge wins over a same-cycle increment.
  always_comb begin
    words_d = words_q;
    pads_d  = pads_q;
    if (clr) begin
      words_d = '0;
      pads_d  = '0;
    end else begin
      if (inc_word) words_d = words_q + 1'b1;
      if (inc_pad)  pads_d  = pads_q + 1'b1;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      words_q <= '0;
      pads_q  <= '0;
    end else begin
      words_q <= words_d;
      pads_q  <= pads_d;
    end
  end

  assign stat_words = words_q;
  assign stat_pads  = pads_q;

endmodule

// File: rtl/stream_packer_8to32.sv
// Packs an 8-bit Xillybus write stream little-endian into 32-bit FIFO words, flushing on close.
// Optional counters are built when STREAM_PACKER_STATS_EN is defined; otherwise stat outputs read 0.
module stream_packer_8to32
  import stream_packer_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE       = PAD_DEFAULT,
  parameter bit         FLUSH_ON_CLOSE = 1'b1
) (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  input  logic        in_wren,
  input  logic [7:0]  in_data,
  input  logic        in_open,
  output logic        in_full,
  output logic        out_wr_en,
  output logic [31:0] out_din,
  input  logic        out_full,
  output logic        idle,
  output logic [31:0] stat_words,
  output logic [15:0] stat_pads
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [23:0]       asm_word_q, asm_word_d;
  logic              pend_vld_q, pend_vld_d;
  logic [31:0]       pend_word_q, pend_word_d;
  logic              flush_req_q, flush_req_d;
  logic              open_d_q;

  logic accept;
  logic load_flush;
  logic close_evt;

  assign in_full    = (pend_vld_q && (lane_q == 2'd3)) || flush_req_q;
  assign out_wr_en  = pend_vld_q && !out_full;
  assign out_din    = pend_word_q;
  assign idle       = (lane_q == 2'd0) && !pend_vld_q && !flush_req_q;
  assign accept     = in_wren && !in_full;
  assign load_flush = flush_req_q && !pend_vld_q;

  always_comb begin
    lane_d      = lane_q;
    asm_word_d  = asm_word_q;
    pend_vld_d  = pend_vld_q;
    pend_word_d = pend_word_q;
    flush_req_d = flush_req_q;
    close_evt   = 1'b0;

    if (out_wr_en) pend_vld_d = 1'b0;

    if (load_flush) begin
      pend_word_d = pad_word(asm_word_q, lane_q, PAD_BYTE);
      pend_vld_d  = 1'b1;
      lane_d      = '0;
      asm_word_d  = '0;
      flush_req_d = 1'b0;
    end else if (accept) begin
      case (lane_q)
        2'd0: asm_word_d[7:0]   = in_data;
        2'd1: asm_word_d[15:8]  = in_data;
        2'd2: asm_word_d[23:16] = in_data;
        default: begin
          pend_word_d = {in_data, asm_word_q};
          pend_vld_d  = 1'b1;
        end
      endcase
      lane_d = lane_q + 1'b1;
    end

    // Close looks at the lane after any same-cycle accept so no accepted byte is lost.
    close_evt = open_d_q && !in_open && (lane_d != '0) && !flush_req_q;
    if (close_evt) begin
      if (FLUSH_ON_CLOSE) begin
        flush_req_d = 1'b1;
      end else begin
        lane_d     = '0;
        asm_word_d = '0;
      end
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      lane_q      <= '0;
      asm_word_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_word_q <= '0;
      flush_req_q <= 1'b0;
      open_d_q    <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      asm_word_q  <= asm_word_d;
      pend_vld_q  <= pend_vld_d;
      pend_word_q <= pend_word_d;
      flush_req_q <= flush_req_d;
      open_d_q    <= in_open;
    end
  end

`ifdef STREAM_PACKER_STATS_EN
  logic open_rise;
  assign open_rise = !open_d_q && in_open;

  stream_packer_stats u_stats (
    .bus_clk    (bus_clk),
    .bus_rst_n  (bus_rst_n),
    .clr        (open_rise),
    .inc_word   (out_wr_en),
    .inc_pad    (load_flush),
    .stat_words (stat_words),
    .stat_pads  (stat_pads)
  );
`else
  assign stat_words = '0;
  assign stat_pads  = '0;
`endif

endmodule

// File: tb/tb_stream_packer_8to32.sv
// Directed self-checking bench for stream_packer_8to32 (flush and discard-on-close builds).
module tb_stream_packer_8to32;

`ifdef STREAM_PACKER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        bus_clk;
  logic        bus_rst_n;
  logic        in_wren;
  logic [7:0]  in_data;
  logic        in_open;
  logic        out_full;

  logic        in_full, out_wr_en, idle;
  logic [31:0] out_din, stat_words;
  logic [15:0] stat_pads;

  logic        nf_in_full, nf_wr_en, nf_idle;
  logic [31:0] nf_din, nf_stat_words;
  logic [15:0] nf_stat_pads;

  int errors = 0;
  int checks = 0;

  stream_packer_8to32 dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .in_wren(in_wren), .in_data(in_data), .in_open(in_open), .in_full(in_full),
    .out_wr_en(out_wr_en), .out_din(out_din), .out_full(out_full),
    .idle(idle), .stat_words(stat_words), .stat_pads(stat_pads)
  );

  stream_packer_8to32 #(.FLUSH_ON_CLOSE(1'b0)) dut_nf (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .in_wren(in_wren), .in_data(in_data), .in_open(in_open), .in_full(nf_in_full),
    .out_wr_en(nf_wr_en), .out_din(nf_din), .out_full(out_full),
    .idle(nf_idle), .stat_words(nf_stat_words), .stat_pads(nf_stat_pads)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge bus_clk);
  endtask

  task automatic next();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic do_reset();
    bus_rst_n = 1'b0;
    in_wren   = 1'b0;
    in_data   = 8'h00;
    in_open   = 1'b0;
    out_full  = 1'b0;
    repeat (2) @(posedge bus_clk);
    #1 bus_rst_n = 1'b1;
    next();
    in_open = 1'b1;
    next();
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    in_wren = 1'b1;
    in_data = b;
    sample();
    chk(tag, in_full, 1'b0);
    next();
  endtask

  initial begin
    bus_rst_n = 1'b0;
    in_wren   = 1'b0;
    in_data   = 8'h00;
    in_open   = 1'b0;
    out_full  = 1'b0;

    // Reset values
    #3;
    chk("rst_in_full", in_full, 1'b0);
    chk("rst_wr_en", out_wr_en, 1'b0);
    chk("rst_din", out_din, 32'h0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_stat_words", stat_words, 32'h0);

    // 1: back-to-back bytes 11..88
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_wren = 1'b1;
      in_data = 8'(8'h11 * (i + 1));
      sample();
      chk("t1_in_full", in_full, 1'b0);
      chk("t1_wr_en", out_wr_en, 1'(i == 4));
      if (i == 4) chk("t1_din0", out_din, 32'h44332211);
      next();
    end
    in_wren = 1'b0;
    sample();
    chk("t1_wr_en_w1", out_wr_en, 1'b1);
    chk("t1_din1", out_din, 32'h88776655);
    next();
    sample();
    chk("t1_wr_en_fall", out_wr_en, 1'b0);
    chk("t1_idle", idle, 1'b1);
    chk("t1_stat_words", stat_words, (STATS != 0) ? 32'd2 : 32'd0);

    // 2: partial word flushed on close
    do_reset();
    for (int i = 0; i < 3; i++) send(8'(8'hAA + 8'h11 * i), "t2_in_full_send");
    in_wren = 1'b0;
    in_open = 1'b0;
    sample();
    chk("t2_idle_busy", idle, 1'b0);
    chk("t2_wr_en_close", out_wr_en, 1'b0);
    next();
    sample();
    chk("t2_in_full_flush", in_full, 1'b1);
    chk("t2_wr_en_wait", out_wr_en, 1'b0);
    next();
    sample();
    chk("t2_wr_en", out_wr_en, 1'b1);
    chk("t2_din", out_din, 32'h00CCBBAA);
    chk("t2_in_full_after", in_full, 1'b0);
    next();
    sample();
    chk("t2_wr_en_fall", out_wr_en, 1'b0);
    chk("t2_idle", idle, 1'b1);
    chk("t2_stat_pads", stat_pads, (STATS != 0) ? 16'd1 : 16'd0);
    chk("t2_stat_words", stat_words, (STATS != 0) ? 32'd1 : 32'd0);

    // 3: downstream stall, backpressure at lane 3
    do_reset();
    out_full = 1'b1;
    for (int i = 0; i < 7; i++) send(8'(i + 1), "t3_in_full_send");
    in_wren = 1'b0;
    sample();
    chk("t3_in_full_stall", in_full, 1'b1);
    chk("t3_wr_en_stall", out_wr_en, 1'b0);
    chk("t3_din_held", out_din, 32'h04030201);
    chk("t3_idle", idle, 1'b0);
    next();
    next();
    out_full = 1'b0;
    in_wren  = 1'b1;
    in_data  = 8'h08;
    sample();
    chk("t3_wr_en_release", out_wr_en, 1'b1);
    chk("t3_din_release", out_din, 32'h04030201);
    chk("t3_in_full_release", in_full, 1'b1);
    next();
    sample();
    chk("t3_in_full_accept", in_full, 1'b0);
    chk("t3_wr_en_gap", out_wr_en, 1'b0);
    next();
    in_wren = 1'b0;
    sample();
    chk("t3_wr_en_w2", out_wr_en, 1'b1);
    chk("t3_din_w2", out_din, 32'h08070605);
    next();

    // 4: flush queued behind a stalled word, reopen during the wait
    do_reset();
    out_full = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(i + 1), "t4_in_full_send");
    send(8'hE1, "t4_in_full_e1");
    send(8'hE2, "t4_in_full_e2");
    in_wren = 1'b0;
    in_open = 1'b0;
    next();
    sample();
    chk("t4_in_full_flushreq", in_full, 1'b1);
    chk("t4_wr_en_stall", out_wr_en, 1'b0);
    in_wren = 1'b1;
    in_data = 8'h99;
    in_open = 1'b1;
    next();
    sample();
    chk("t4_in_full_reopen", in_full, 1'b1);
    in_wren  = 1'b0;
    next();
    out_full = 1'b0;
    sample();
    chk("t4_wr_en_first", out_wr_en, 1'b1);
    chk("t4_din_first", out_din, 32'h04030201);
    chk("t4_in_full_first", in_full, 1'b1);
    next();
    sample();
    chk("t4_wr_en_load", out_wr_en, 1'b0);
    chk("t4_in_full_load", in_full, 1'b1);
    next();
    sample();
    chk("t4_wr_en_flush", out_wr_en, 1'b1);
    chk("t4_din_flush", out_din, 32'h0000E2E1);
    chk("t4_in_full_done", in_full, 1'b0);
    next();
    sample();
    chk("t4_idle", idle, 1'b1);
    chk("t4_stat_pads", stat_pads, (STATS != 0) ? 16'd1 : 16'd0);

    // 5: discard-on-close build
    do_reset();
    send(8'h01, "t5_nf_send");
    send(8'h02, "t5_nf_send");
    in_wren = 1'b0;
    in_open = 1'b0;
    sample();
    chk("t5_nf_wr_en_close", nf_wr_en, 1'b0);
    next();
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t5_nf_wr_en_closed", nf_wr_en, 1'b0);
      chk("t5_nf_idle", nf_idle, 1'b1);
      chk("t5_nf_in_full", nf_in_full, 1'b0);
      next();
    end
    in_open = 1'b1;
    next();
    for (int i = 0; i < 4; i++) begin
      in_wren = 1'b1;
      in_data = 8'(i + 3);
      sample();
      chk("t5_nf_in_full_send", nf_in_full, 1'b0);
      chk("t5_nf_wr_en_send", nf_wr_en, 1'b0);
      next();
    end
    in_wren = 1'b0;
    sample();
    chk("t5_nf_wr_en", nf_wr_en, 1'b1);
    chk("t5_nf_din", nf_din, 32'h06050403);
    next();

    // 6: asynchronous reset mid-word with a pending word
    do_reset();
    out_full = 1'b1;
    for (int i = 0; i < 6; i++) send(8'(i + 1), "t6_in_full_send");
    in_wren = 1'b0;
    sample();
    chk("t6_idle_busy", idle, 1'b0);
    #2;
    bus_rst_n = 1'b0;
    out_full  = 1'b0;
    #1;
    chk("t6_rst_in_full", in_full, 1'b0);
    chk("t6_rst_wr_en", out_wr_en, 1'b0);
    chk("t6_rst_din", out_din, 32'h0);
    chk("t6_rst_idle", idle, 1'b1);
    chk("t6_rst_stat_words", stat_words, 32'h0);
    @(negedge bus_clk);
    #2 bus_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next();
      sample();
      chk("t6_post_wr_en", out_wr_en, 1'b0);
      chk("t6_post_idle", idle, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
